rr_sel_arbiter: RTL and testbench

Round-robin arbiter that shares one decoded select resource among `N = 1 << C` requesters. It accepts a request vector, grants exactly one requester at a time, and drives both a one-hot grant and its binary index. The binary index is the C-bit select of the downstream one-hot decoder; the one-hot grant is the decoder's expected output, for cross-checking. The block sits between the requesting agents and the shared decoder/datapath, and holds each grant until the owner signals completion.

---
 rtl/rr_sel_arbiter.sv | 104 ++++++++++
 tb/tb_rr_sel_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter over N = 1<<C requesters with one-hot and binary grant outputs.
// Optional grant timeout is compiled in with the ARB_TIMEOUT_EN macro.
module rr_sel_arbiter #(
  parameter int C       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [(1<<C)-1:0]   req,
  input  logic                done,
  output logic [(1<<C)-1:0]   gnt,
  output logic [C-1:0]        gnt_idx,
  output logic                gnt_valid,
  output logic                err
);
  localparam int N = 1 << C;
  localparam logic [N-1:0] ONE = N'(1);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rr_sel_arbiter: TIMEOUT out of range 2..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;

  logic [C-1:0] ptr, ptr_nx, arb_ptr, win, idx;
  logic         any, load, rel, timeout;

  // On release the scan starts one past the owner, so the owner ends up last.
  assign arb_ptr = (state == BUSY) ? gnt_idx + C'(1) : ptr;
  assign rel     = (state == BUSY) && (done || timeout);

  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = arb_ptr + C'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    load     = 1'b0;
    case (state)
      IDLE: if (any) begin
        state_nx = BUSY;
        load     = 1'b1;
      end
      BUSY: if (rel) begin
        ptr_nx = gnt_idx + C'(1);
        if (any) load = 1'b1;
        else     state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt_valid <= (state_nx == BUSY);
      if (load) begin
        gnt     <= ONE << win;
        gnt_idx <= win;
      end else if (state_nx == IDLE) begin
        gnt     <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt;

  assign timeout = (state == BUSY) && !done && (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (load)                cnt <= '0;
      else if (state == BUSY)  cnt <= cnt + 16'd1;
      if (timeout)             err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (C=2, TIMEOUT=4); timeout checks follow ARB_TIMEOUT_EN.
module tb_rr_sel_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       err;

  int errors = 0;
  int checks = 0;

  rr_sel_arbiter #(.C(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] g, input logic [1:0] i);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(i));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(1'b1));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.gnt", 32'(gnt), 0);
    chk("rst.idx", 32'(gnt_idx), 0);
    chk("rst.vld", 32'(gnt_valid), 0);
    chk("rst.err", 32'(err), 0);
    rst_n = 1'b1;
    step();
    chk_gnt("first", 4'b0001, 2'd0);

    // rotation: done every 2nd cycle, no idle gap
    for (int k = 0; k < 4; k++) begin
      done = 1'b0;
      step();
      chk_gnt("rot.hold", 4'b0001 << k, 2'(k));
      done = 1'b1;
      step();
      chk_gnt("rot.next", 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4));
    end

    // lock and wrap
    req = 4'b1000; done = 1'b1;
    step();
    chk_gnt("lock.g3", 4'b1000, 2'd3);
    req = 4'b0101; done = 1'b0;
    step();
    chk_gnt("lock.held", 4'b1000, 2'd3);
    done = 1'b1;
    step();
    chk_gnt("wrap", 4'b0001, 2'd0);

    // release to idle
    req = 4'b0100;
    step();
    chk_gnt("idle.g2", 4'b0100, 2'd2);
    req = 4'b0000;
    step();
    chk("idle.vld", 32'(gnt_valid), 0);
    chk("idle.gnt", 32'(gnt), 0);
    step();
    chk("idle.done.vld", 32'(gnt_valid), 0);
    done = 1'b0; req = 4'b1111;
    step();
    chk_gnt("idle.ptr3", 4'b1000, 2'd3);

    // async reset mid-grant
    req = 4'b0010; done = 1'b1;
    step();
    chk_gnt("ar.g1", 4'b0010, 2'd1);
    done = 1'b0; req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.gnt", 32'(gnt), 0);
    chk("ar.idx", 32'(gnt_idx), 0);
    chk("ar.vld", 32'(gnt_valid), 0);
    req = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_gnt("ar.regrant", 4'b0010, 2'd1);
    req = 4'b1111; done = 1'b1;
    step();
    chk_gnt("ar.ptr2", 4'b0100, 2'd2);
    done = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_gnt("ar.ptr0", 4'b0001, 2'd0);

    // timeout scenario
    rst_n = 1'b0;
    req   = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    step();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      chk_gnt("to.hold", 4'b0001, 2'd0);
      chk("to.err0", 32'(err), 0);
      if (k < 3) step();
    end
    step();
    chk_gnt("to.next", 4'b0010, 2'd1);
    chk("to.err1", 32'(err), 1);
    for (int k = 0; k < 4; k++) step();
    chk_gnt("to.wrap", 4'b0001, 2'd0);
    chk("to.sticky", 32'(err), 1);
`else
    for (int k = 0; k < 8; k++) begin
      chk_gnt("noto.hold", 4'b0001, 2'd0);
      chk("noto.err", 32'(err), 0);
      step();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
